vend_ctrl: RTL
==============

# vend_ctrl

Parametrised vending-machine controller, and the successor to the fixed six-item coin/stock/purchase datapath. It debounce-free edge-detects coin and purchase buttons and accumulates saturating credit. It validates a one-hot selection against per-item price and stock, then vends and either keeps the balance or returns it as greedy coin change. Outputs are registered and feed the existing seven-segment and LED display path.

## Interface
- N_ITEMS, 6, number of products
- STOCK_W, 4, width of each stock counter
- MAX_STOCK, 9, stock level after reset or restock
- CREDIT_W, 7, credit register width
- MAX_CREDIT, 99, credit saturation ceiling
- PRICES, {7'd15,7'd12,7'd10,7'd7,7'd5,7'd3}, packed N_ITEMS*CREDIT_W price table, item 0 in the LSBs
- AUTO_CHANGE, 1, 1 = return the remaining credit after a vend; 0 = keep the balance for further purchases
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- rmb1, rmb5, rmb10  in  1 each  coin buttons (levels)
- ok  in  1  purchase button (level)
- cancel  in  1  refund button (level)
- commodity  in  N_ITEMS  selection, must be one-hot at purchase
- restock  in  N_ITEMS  per-item refill to MAX_STOCK (level)
- credit  out  CREDIT_W  current balance
- stock  out  N_ITEMS*STOCK_W  packed stock counters
- avail  out  N_ITEMS  stock[i]!=0 (LEDs)
- busy  out  1  FSM not in IDLE
- vend  out  1  one-cycle dispense pulse
- vend_idx  out  $clog2(N_ITEMS)  index of the dispensed item, held until the next vend
- chg1, chg5, chg10  out  1 each  one-cycle change-coin pulses
- coin_reject  out  1  one-cycle pulse, coin not credited
- err  out  1  one-cycle pulse, purchase refused
- err_code  out  2  0 none, 1 bad selection, 2 out of stock, 3 insufficient credit; held until the next ok edge

## Operation
- Edge detect: the block registers rmb1, rmb5, rmb10, ok and cancel. An event is `x & ~x_q`, so a held button produces exactly one event.
- FSM states: IDLE, CHECK, VEND, CHANGE.
- IDLE accepts events in this priority: cancel > ok > coin.
  - cancel with credit>0 goes to CHANGE. cancel with credit==0 is ignored.
  - ok goes to CHECK. It also clears err_code to 0 and latches commodity.
  - A coin of value v applies credit+=v. If credit+v > MAX_CREDIT, credit is unchanged and coin_reject pulses.
- Several coin events in one cycle: only the highest value (10>5>1) is considered. The others are dropped, with one coin_reject pulse for the cycle.
- A coin event in any state other than IDLE, or one that loses to cancel/ok in the same cycle, gives coin_reject and no credit.
- CHECK (1 cycle) checks the latched selection in this order:
  - not exactly one-hot → err_code 1
  - stock==0 → err_code 2
  - credit<price → err_code 3
  - On any error: err pulses and the FSM returns to IDLE. Otherwise it goes to VEND.
- VEND (1 cycle):
  - vend pulses and vend_idx is updated.
  - stock[idx] decrements and credit -= price.
  - Next state is CHANGE if AUTO_CHANGE=1 and the new credit > 0, else IDLE.
- CHANGE emits one coin per cycle, greedily: credit≥10 → chg10, credit -10; else ≥5 → chg5, credit -5; else chg1, credit -1. It returns to IDLE in the cycle after the pulse that brings credit to 0.
- Restock can occur in any state: stock[i] is set to MAX_STOCK. If a restock and a VEND decrement hit the same item in the same cycle, the restock wins.
- Arithmetic: credit never exceeds MAX_CREDIT and never underflows. Stock saturates at 0 and is never decremented below it.

## Timing
- All outputs are registered, except avail, which is a combinational compare on the stock register.
- Reset values: credit=0, stock[i]=MAX_STOCK, busy=0, vend=0, vend_idx=0, chg*=0, coin_reject=0, err=0, err_code=0, FSM=IDLE, and all edge registers = 0.
- If a button is high when reset releases, it produces an event only if it was sampled low first.
- Coin latency: rising input at cycle t is sampled as an event at t and seen on credit/coin_reject at t+1.
- Purchase latency: with an ok edge at t, CHECK runs at t+1, vend or err is asserted at t+2, and the first change pulse is at t+3.
- Refund cycle count: the refund takes floor(c/10) + floor((c%10)/5) + c%5 cycles.
- Reset mid-operation (any state) aborts the operation. Credit is lost, no change is emitted, and stock returns to MAX_STOCK.
- commodity is sampled only on the ok-event cycle. Changes after that are ignored until the next ok.

## Test plan
- Reset, then pulse rmb10, rmb5, rmb1 one at a time → credit is 10, 15, 16 on successive post-edge cycles, and avail=6'b111111.
- Credit 16, commodity=6'b000100 (price 7), ok edge → vend at t+2 with vend_idx=2, stock[2]=8, then chg5, chg1, chg1, chg1, chg1 on consecutive cycles, and credit=0 with busy=0 the cycle after.
- Credit 3, select item 1 (price 5), ok → err at t+2 with err_code=3 and credit still 3. Then commodity=6'b000011 with ok → err_code=1.
- Vend item 0 nine times, then ok again → err_code=2 and avail[0]=0. Then restock[0] for 1 cycle → stock[0]=9; restock coincident with a VEND on item 0 → stock[0]=9.
- Credit 95, rmb10 → coin_reject and credit stays 95. rmb5 → credit 100 is not allowed, so coin_reject and credit stays 95; rmb1 → 96. Then cancel → chg10 ×9, chg5, chg1 (96 = 90+5+1, 11 cycles), credit 0.
- AUTO_CHANGE=0 with credit 20: buy item 0 → credit 17, no chg pulses. Assert reset during a CHANGE sequence → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/vend_ctrl.sv
// ---------------------------------------------------------------------------
// vend_ctrl - parametrised vending-machine controller
//
// Edge-detects coin/purchase/refund buttons, accumulates saturating credit,
// validates a one-hot selection against per-item price and stock, dispenses
// and optionally returns the remaining balance as greedy coin change.
//
// Ports
//   clk, reset            : single rising-edge clock, synchronous active-high reset
//   rmb1, rmb5, rmb10     : coin buttons (levels, edge-detected)
//   ok, cancel            : purchase / refund buttons (levels, edge-detected)
//   commodity             : one-hot item selection, sampled on the ok event
//   restock               : per-item refill to MAX_STOCK (level)
//   credit                : current balance
//   stock                 : packed stock counters, item 0 in the LSBs
//   avail                 : per-item stock != 0 (combinational on stock register)
//   busy                  : controller not idle
//   vend, vend_idx        : dispense pulse and index of the dispensed item
//   chg1, chg5, chg10     : one-cycle change-coin pulses
//   coin_reject           : one-cycle pulse, a coin event was not credited
//   err, err_code         : refused purchase pulse and held reason code
// ---------------------------------------------------------------------------
module vend_ctrl #(
  parameter int                          N_ITEMS     = 6,
  parameter int                          STOCK_W     = 4,
  parameter int                          MAX_STOCK   = 9,
  parameter int                          CREDIT_W    = 7,
  parameter int                          MAX_CREDIT  = 99,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES      = {7'd15, 7'd12, 7'd10, 7'd7, 7'd5, 7'd3},
  parameter bit                          AUTO_CHANGE = 1'b1,
  localparam int                         IDX_W       = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rmb1,
  input  logic                         rmb5,
  input  logic                         rmb10,
  input  logic                         ok,
  input  logic                         cancel,
  input  logic [N_ITEMS-1:0]           commodity,
  input  logic [N_ITEMS-1:0]           restock,
  output logic [CREDIT_W-1:0]          credit,
  output logic [N_ITEMS*STOCK_W-1:0]   stock,
  output logic [N_ITEMS-1:0]           avail,
  output logic                         busy,
  output logic                         vend,
  output logic [IDX_W-1:0]             vend_idx,
  output logic                         chg1,
  output logic                         chg5,
  output logic                         chg10,
  output logic                         coin_reject,
  output logic                         err,
  output logic [1:0]                   err_code
);

  localparam int                  CNT_W      = $clog2(N_ITEMS + 1);
  localparam logic [CREDIT_W:0]   CREDIT_MAX = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [STOCK_W-1:0]  STOCK_FULL = STOCK_W'(MAX_STOCK);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_VEND,
    S_CHANGE
  } state_t;

  // -------------------------------------------------------------------------
  // Button edge detection. Bit order: {cancel, ok, rmb10, rmb5, rmb1}.
  // armed_q keeps a button that is already high across reset release from
  // producing an event until it has been seen low at least once.
  // -------------------------------------------------------------------------
  logic [4:0] btn;
  logic [4:0] btn_q;
  logic [4:0] armed_q;
  logic [4:0] btn_ev;

  assign btn    = {cancel, ok, rmb10, rmb5, rmb1};
  assign btn_ev = btn & ~btn_q & armed_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q   <= '0;
      armed_q <= ~btn;
    end else begin
      btn_q   <= btn;
      armed_q <= armed_q | ~btn;
    end
  end

  logic ev_rmb1, ev_rmb5, ev_rmb10, ev_ok, ev_cancel;
  assign ev_rmb1   = btn_ev[0];
  assign ev_rmb5   = btn_ev[1];
  assign ev_rmb10  = btn_ev[2];
  assign ev_ok     = btn_ev[3];
  assign ev_cancel = btn_ev[4];

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic [N_ITEMS-1:0]   sel_q, sel_d;
  logic                 busy_q;
  logic                 vend_q, vend_d;
  logic [IDX_W-1:0]     vend_idx_q, vend_idx_d;
  logic                 chg1_q, chg1_d;
  logic                 chg5_q, chg5_d;
  logic                 chg10_q, chg10_d;
  logic                 coin_reject_q, coin_reject_d;
  logic                 err_q, err_d;
  logic [1:0]           err_code_q, err_code_d;
  logic [STOCK_W-1:0]   stock_q [N_ITEMS];
  logic                 dec_en;

  // -------------------------------------------------------------------------
  // Price table unpacked from the parameter, item 0 in the LSBs.
  // -------------------------------------------------------------------------
  logic [CREDIT_W-1:0] price_tbl [N_ITEMS];

  for (genvar gi = 0; gi < N_ITEMS; gi++) begin : g_price
    assign price_tbl[gi] = PRICES[gi*CREDIT_W +: CREDIT_W];
  end

  // -------------------------------------------------------------------------
  // Selection decode: population count plus index of the (last) set bit.
  // The index is only meaningful when the count is exactly one.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0]    sel_cnt;
  logic [IDX_W-1:0]    sel_idx;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_empty;

  always_comb begin
    sel_cnt = '0;
    sel_idx = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (sel_q[i]) begin
        sel_cnt = sel_cnt + CNT_W'(1);
        sel_idx = IDX_W'(i);
      end
    end
  end

  assign sel_price = price_tbl[sel_idx];
  assign sel_empty = (stock_q[sel_idx] == '0);

  // -------------------------------------------------------------------------
  // Coin arbitration: highest value wins when several arrive together.
  // -------------------------------------------------------------------------
  logic                coin_any;
  logic                coin_multi;
  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   coin_sum;

  assign coin_any   = ev_rmb1 | ev_rmb5 | ev_rmb10;
  assign coin_multi = (ev_rmb1 & ev_rmb5) | (ev_rmb1 & ev_rmb10) | (ev_rmb5 & ev_rmb10);
  assign coin_val   = ev_rmb10 ? (CREDIT_W + 1)'(10) :
                      ev_rmb5  ? (CREDIT_W + 1)'(5)  : (CREDIT_W + 1)'(1);
  assign coin_sum   = {1'b0, credit_q} + coin_val;

  // -------------------------------------------------------------------------
  // Next-state and registered-output logic. Outputs are computed from the
  // transition into a state, so a pulse is visible during the state it
  // belongs to (vend during VEND, each change coin during CHANGE).
  // -------------------------------------------------------------------------
  logic emit_chg;

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    sel_d         = sel_q;
    vend_d        = 1'b0;
    vend_idx_d    = vend_idx_q;
    chg1_d        = 1'b0;
    chg5_d        = 1'b0;
    chg10_d       = 1'b0;
    coin_reject_d = 1'b0;
    err_d         = 1'b0;
    err_code_d    = err_code_q;
    dec_en        = 1'b0;
    emit_chg      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ev_cancel) begin
          coin_reject_d = coin_any;
          if (credit_q != '0) begin
            state_d  = S_CHANGE;
            emit_chg = 1'b1;
          end
        end else if (ev_ok) begin
          coin_reject_d = coin_any;
          state_d       = S_CHECK;
          err_code_d    = 2'd0;
          sel_d         = commodity;
        end else if (coin_any) begin
          if (coin_sum > CREDIT_MAX) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d      = coin_sum[CREDIT_W-1:0];
            coin_reject_d = coin_multi;
          end
        end
      end

      S_CHECK: begin
        coin_reject_d = coin_any;
        if (sel_cnt != CNT_W'(1)) begin
          err_d      = 1'b1;
          err_code_d = 2'd1;
          state_d    = S_IDLE;
        end else if (sel_empty) begin
          err_d      = 1'b1;
          err_code_d = 2'd2;
          state_d    = S_IDLE;
        end else if (credit_q < sel_price) begin
          err_d      = 1'b1;
          err_code_d = 2'd3;
          state_d    = S_IDLE;
        end else begin
          // Dispense commits here so that vend, stock and credit all
          // change together in the VEND cycle.
          state_d    = S_VEND;
          vend_d     = 1'b1;
          vend_idx_d = sel_idx;
          credit_d   = credit_q - sel_price;
          dec_en     = 1'b1;
        end
      end

      S_VEND: begin
        coin_reject_d = coin_any;
        if (AUTO_CHANGE && (credit_q != '0)) begin
          state_d  = S_CHANGE;
          emit_chg = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CHANGE: begin
        coin_reject_d = coin_any;
        if (credit_q == '0) begin
          state_d = S_IDLE;
        end else begin
          emit_chg = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Greedy change coin; only reached with credit_q > 0, so no underflow.
    if (emit_chg) begin
      if (credit_q >= CREDIT_W'(10)) begin
        chg10_d  = 1'b1;
        credit_d = credit_q - CREDIT_W'(10);
      end else if (credit_q >= CREDIT_W'(5)) begin
        chg5_d   = 1'b1;
        credit_d = credit_q - CREDIT_W'(5);
      end else begin
        chg1_d   = 1'b1;
        credit_d = credit_q - CREDIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      sel_q         <= '0;
      busy_q        <= 1'b0;
      vend_q        <= 1'b0;
      vend_idx_q    <= '0;
      chg1_q        <= 1'b0;
      chg5_q        <= 1'b0;
      chg10_q       <= 1'b0;
      coin_reject_q <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      sel_q         <= sel_d;
      busy_q        <= (state_d != S_IDLE);
      vend_q        <= vend_d;
      vend_idx_q    <= vend_idx_d;
      chg1_q        <= chg1_d;
      chg5_q        <= chg5_d;
      chg10_q       <= chg10_d;
      coin_reject_q <= coin_reject_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
    end
  end

  // -------------------------------------------------------------------------
  // Per-item stock counters. Restock takes priority over a same-cycle
  // decrement; the decrement never goes below zero.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_ITEMS; gi++) begin : g_stock
    always_ff @(posedge clk) begin
      if (reset) begin
        stock_q[gi] <= STOCK_FULL;
      end else if (restock[gi]) begin
        stock_q[gi] <= STOCK_FULL;
      end else if (dec_en && (sel_idx == IDX_W'(gi)) && (stock_q[gi] != '0)) begin
        stock_q[gi] <= stock_q[gi] - STOCK_W'(1);
      end
    end

    assign stock[gi*STOCK_W +: STOCK_W] = stock_q[gi];
    assign avail[gi]                    = (stock_q[gi] != '0);
  end

  assign credit      = credit_q;
  assign busy        = busy_q;
  assign vend        = vend_q;
  assign vend_idx    = vend_idx_q;
  assign chg1        = chg1_q;
  assign chg5        = chg5_q;
  assign chg10       = chg10_q;
  assign coin_reject = coin_reject_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule
